// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: buffers FP16 samples and sequences them through an external adder into a running sum.
// Optional saturation/overflow tracking is enabled by defining FP16_ACC_SAT_EN.
module fp16_accum_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_sub,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             ovf,
    output logic [15:0]      add_c,
    output logic [15:0]      add_d,
    output logic             add_ch,
    input  logic [15:0]      add_a
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, ADD} state_t;

    state_t           state, state_nx;
    logic [16:0]      mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic [16:0]      opr;
    logic [15:0]      acc, acc_nx;
    logic [CNT_W-1:0] cnt, len_q;
    logic             full, empty, push, pop, last;

    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty    = wp == rp;
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == FETCH) && !empty;
    assign last     = ({1'b0, cnt} + (CNT_W+1)'(1)) == {1'b0, len_q};
    assign busy     = state != IDLE;

`ifdef FP16_ACC_SAT_EN
    logic ovf_q;
    assign acc_nx = ovf_q ? acc : add_a;
    assign ovf    = ovf_q;

    // Sticky overflow: cleared by a new run, set when the adder returns Inf/NaN.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (state == IDLE && start)
            ovf_q <= 1'b0;
        else if (state == ADD && add_a[14:10] == 5'h1F)
            ovf_q <= 1'b1;
    end
`else
    assign acc_nx = add_a;
    assign ovf    = 1'b0;
`endif

    // Next state and adder operand drive; operands are zero outside ADD.
    always_comb begin
        state_nx = state;
        add_c    = '0;
        add_d    = '0;
        add_ch   = 1'b0;
        case (state)
            IDLE:    state_nx = (start && len != '0) ? FETCH : IDLE;
            FETCH:   state_nx = empty ? FETCH : ADD;
            ADD: begin
                add_c    = acc;
                add_d    = opr[15:0];
                add_ch   = opr[16];
                state_nx = last ? IDLE : FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, sample FIFO, operand capture and accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wp     <= '0;
            rp     <= '0;
            opr    <= '0;
            acc    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (push) begin
                mem[wp[AW-1:0]] <= {in_sub, in_data};
                wp              <= wp + 1'b1;
            end
            if (pop) begin
                opr <= mem[rp[AW-1:0]];
                rp  <= rp + 1'b1;
            end
            if (state == IDLE && start) begin
                if (len == '0) begin
                    result <= '0;
                    done   <= 1'b1;
                end else begin
                    acc   <= '0;
                    cnt   <= '0;
                    len_q <= len;
                end
            end
            if (state == ADD) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result <= acc_nx;
                    done   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp16_accum_seq.sv
// tb_fp16_accum_seq: directed scoreboard bench for fp16_accum_seq with a behavioural FP16 adder.
module tb_fp16_accum_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_sub, start;
    logic [15:0] in_data;
    logic [7:0]  len;
    logic        in_ready, busy, done, ovf, add_ch;
    logic [15:0] result, add_c, add_d, add_a;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb [$];

    fp16_accum_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sub(in_sub), .start(start), .len(len),
        .busy(busy), .done(done), .result(result), .ovf(ovf),
        .add_c(add_c), .add_d(add_d), .add_ch(add_ch), .add_a(add_a)
    );

    always #5 clk = ~clk;

    function automatic real dec(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        m = h[9:0];
        if (e == 0) m = m / 1024.0 * 2.0 ** (-14);
        else        m = (1.0 + m / 1024.0) * 2.0 ** (e - 15);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] enc(input real x);
        logic s;
        real  a;
        int   e, m;
        s = x < 0.0;
        a = s ? -x : x;
        if (a == 0.0) return 16'h0000;
        if (a >= 65520.0) return {s, 5'h1F, 10'h000};
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -14) begin a = a * 2.0; e--; end
        if (a < 1.0) begin
            m = $rtoi(a * 1024.0 + 0.5);
            return {s, 5'd0, m[9:0]};
        end
        m = $rtoi(a * 1024.0 + 0.5);
        if (m == 2048) begin m = 1024; e++; end
        if (e > 15) return {s, 5'h1F, 10'h000};
        m = m - 1024;
        return {s, 5'(e + 15), m[9:0]};
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] c, input logic [15:0] d, input logic sub);
        if (c[14:10] == 5'h1F) return c;
        if (d[14:10] == 5'h1F) return {d[15] ^ sub, d[14:0]};
        return enc(dec(c) + (sub ? -dec(d) : dec(d)));
    endfunction

    always_comb add_a = fp_add(add_c, add_d, add_ch);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 16'h0000);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_add"}, {add_ch, add_c, add_d}, 0);
    endtask

    task automatic run(input logic [7:0] l, input logic [15:0] exp_r, input int exp_lat, input string tag);
        int   lat;
        logic got;
        sb.push_back(exp_r);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        lat   = 0;
        got   = 1'b0;
        while (!got && lat < 100) begin
            lat++;
            @(negedge clk);
            if (lat == 1) chk({tag, "_busy"}, busy, l != 0);
            got = done;
            if (!got) tick();
        end
        chk({tag, "_done"}, got, 1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_result"}, result, sb.pop_front());
        tick();
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        logic seen;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sub   = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        len      = '0;
        repeat (2) tick();
        @(negedge clk);
        reset_chk("reset");
        rst_n = 1'b1;
        tick();

        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b0);
        run(8'd2, 16'h4200, 5, "add2");

        push(16'h4200, 1'b0);
        push(16'h3C00, 1'b1);
        run(8'd2, 16'h4000, 5, "sub");

        push(16'h3C00, 1'b0);
        run(8'd0, 16'h0000, 1, "len0");
        run(8'd1, 16'h3C00, 3, "kept");

        fork
            run(8'd3, 16'h3E00, 17, "stall");
            begin
                for (int i = 0; i < 3; i++) begin
                    repeat (4) tick();
                    push(16'h3800, 1'b0);
                end
            end
        join

        for (int i = 0; i < 4; i++) push(16'h3C00, 1'b0);
        @(negedge clk);
        chk("full_ready", in_ready, 0);
        push(16'h4000, 1'b0);
        fork
            run(8'd4, 16'h4400, 9, "full");
            begin
                repeat (2) @(negedge clk);
                chk("ready_before_pop", in_ready, 0);
                @(negedge clk);
                chk("ready_after_pop", in_ready, 1);
            end
        join
        push(16'h3800, 1'b0);
        run(8'd1, 16'h3800, 3, "drop");

        push(16'h7BFF, 1'b0);
        push(16'h7BFF, 1'b0);
        push(16'h3C00, 1'b0);
        run(8'd3, 16'h7C00, 7, "ovf");
`ifdef FP16_ACC_SAT_EN
        chk("ovf_flag", ovf, 1);
`else
        chk("ovf_flag", ovf, 0);
`endif

        push(16'h7BFF, 1'b0);
        push(16'h7BFF, 1'b0);
        push(16'h3C00, 1'b0);
        start = 1'b1;
        len   = 8'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        reset_chk("midrun");

        start = 1'b1;
        len   = 8'd1;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | done;
            tick();
        end
        @(negedge clk);
        chk("flushed_busy", busy, 1);
        chk("flushed_done", seen, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        reset_chk("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
